branch_sequencer: RTL and testbench

- Control-unit slice that executes conditional-branch instructions (brzr/brnz/brpl/brmi). It consumes the CON flag produced by the condition flip-flop.
- Sequences the datapath strobes needed to evaluate the condition, form PC + C, and commit PC only when CON is set.
- Sits between the instruction decoder (start pulse, C2 field) and the datapath register/ALU enables. Also keeps branch/taken statistics for debug.

---
 rtl/branch_sequencer_if.sv | 41 ++++
 rtl/branch_sequencer.sv | 154 +++++++++++++++
 tb/tb_branch_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// Handshake and datapath-strobe bundle between decoder, sequencer and datapath.
// CNT_W sizes the debug statistics counters carried on the bundle.
interface branch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       c2;
    logic             con;
    logic             busy;
    logic             done;
    logic             taken;
    logic [1:0]       c2_q;
    logic             con_in;
    logic             gra;
    logic             r_out;
    logic             pc_out;
    logic             y_in;
    logic             c_out;
    logic             alu_add;
    logic             z_in;
    logic             zlo_out;
    logic             pc_in;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output start, c2, con,
        input  busy, done, taken, c2_q,
        input  con_in, gra, r_out, pc_out, y_in,
        input  c_out, alu_add, z_in, zlo_out, pc_in,
        input  branch_count, taken_count
    );

    modport slave (
        input  start, c2, con,
        output busy, done, taken, c2_q,
        output con_in, gra, r_out, pc_out, y_in,
        output c_out, alu_add, z_in, zlo_out, pc_in,
        output branch_count, taken_count
    );
endinterface

// File: rtl/branch_sequencer.sv
// Conditional-branch control slice: COND -> PCY -> ADDC -> UPD strobe sequence.
// Optional BRANCH_FAST_NOT_TAKEN_EN retires not-taken branches early in PCY.
module branch_sequencer #(
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              reset_n,
    branch_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_COND,
        S_PCY,
        S_ADDC,
        S_UPD
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_taken;
    logic [1:0]       r_c2q;
    logic             r_conin;
    logic             r_gra;
    logic             r_rout;
    logic             r_pcout;
    logic             r_yin;
    logic             r_cout;
    logic             r_add;
    logic             r_zin;
    logic             r_zlo;
    logic [CNT_W-1:0] r_bcnt;
    logic [CNT_W-1:0] r_tcnt;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    // Sequencer: strobe flops are loaded with the decode of the next state,
    // so each strobe is high exactly while the FSM sits in its state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_taken <= 1'b0;
            r_c2q   <= 2'b00;
            r_conin <= 1'b0;
            r_gra   <= 1'b0;
            r_rout  <= 1'b0;
            r_pcout <= 1'b0;
            r_yin   <= 1'b0;
            r_cout  <= 1'b0;
            r_add   <= 1'b0;
            r_zin   <= 1'b0;
            r_zlo   <= 1'b0;
            r_bcnt  <= '0;
            r_tcnt  <= '0;
        end else begin
            r_done  <= 1'b0;
            r_conin <= 1'b0;
            r_gra   <= 1'b0;
            r_rout  <= 1'b0;
            r_pcout <= 1'b0;
            r_yin   <= 1'b0;
            r_cout  <= 1'b0;
            r_add   <= 1'b0;
            r_zin   <= 1'b0;
            r_zlo   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_c2q   <= bus.c2;
                        r_state <= S_COND;
                        r_busy  <= 1'b1;
                        r_gra   <= 1'b1;
                        r_rout  <= 1'b1;
                        r_conin <= 1'b1;
                    end
                end
                S_COND: begin
                    r_state <= S_PCY;
                    r_pcout <= 1'b1;
                    r_yin   <= 1'b1;
                end
                S_PCY: begin
`ifdef BRANCH_FAST_NOT_TAKEN_EN
                    if (!bus.con) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_taken <= 1'b0;
                        r_bcnt  <= sat_inc(r_bcnt);
                    end else begin
                        r_state <= S_ADDC;
                        r_cout  <= 1'b1;
                        r_add   <= 1'b1;
                        r_zin   <= 1'b1;
                    end
`else
                    r_state <= S_ADDC;
                    r_cout  <= 1'b1;
                    r_add   <= 1'b1;
                    r_zin   <= 1'b1;
`endif
                end
                S_ADDC: begin
                    r_state <= S_UPD;
                    r_zlo   <= 1'b1;
                    r_done  <= 1'b1;
                end
                S_UPD: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_taken <= bus.con;
                    r_bcnt  <= sat_inc(r_bcnt);
                    if (bus.con) begin
                        r_tcnt <= sat_inc(r_tcnt);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.taken        = r_taken;
    assign bus.c2_q         = r_c2q;
    assign bus.con_in       = r_conin;
    assign bus.gra          = r_gra;
    assign bus.r_out        = r_rout;
    assign bus.c_out        = r_cout;
    assign bus.alu_add      = r_add;
    assign bus.z_in         = r_zin;
    assign bus.zlo_out      = r_zlo;
    assign bus.pc_in        = r_zlo & bus.con;
    assign bus.branch_count = r_bcnt;
    assign bus.taken_count  = r_tcnt;

`ifdef BRANCH_FAST_NOT_TAKEN_EN
    assign bus.pc_out = r_pcout & bus.con;
    assign bus.y_in   = r_yin & bus.con;
    assign bus.done   = r_done | (r_pcout & ~bus.con);
`else
    assign bus.pc_out = r_pcout;
    assign bus.y_in   = r_yin;
    assign bus.done   = r_done;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer (CNT_W=4) against a
// cycles-since-accept reference model; randomized plus directed scenarios.
module tb_branch_sequencer;
    localparam int CW = 4;
    localparam int VW = 15 + 2 * CW;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    branch_sequencer_if #(.CNT_W(CW)) bif ();

    branch_sequencer #(.CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    // Reference: cycles elapsed since the branch was accepted (0 = idle).
    int          m_age;
    logic        m_taken;
    logic [1:0]  m_c2q;
    logic [CW-1:0] m_bc;
    logic [CW-1:0] m_tc;

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic model_tick();
        if (!reset_n) begin
            m_age = 0; m_taken = 0; m_c2q = 0;
            m_bc = 0; m_tc = 0;
        end else if (m_age == 0) begin
            if (bif.start) begin
                m_age = 1;
                m_c2q = bif.c2;
            end
        end else if (m_age == 4) begin
            m_age = 0;
            m_taken = bif.con;
            m_bc = sat(m_bc);
            if (bif.con) m_tc = sat(m_tc);
`ifdef BRANCH_FAST_NOT_TAKEN_EN
        end else if (m_age == 2 && !bif.con) begin
            m_age = 0;
            m_taken = 0;
            m_bc = sat(m_bc);
`endif
        end else begin
            m_age = m_age + 1;
        end
    endtask

    function automatic logic [VW-1:0] obs_vec();
        return {bif.busy, bif.done, bif.taken, bif.c2_q,
                bif.con_in, bif.gra, bif.r_out,
                bif.pc_out, bif.y_in,
                bif.c_out, bif.alu_add, bif.z_in,
                bif.zlo_out, bif.pc_in,
                bif.branch_count, bif.taken_count};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic a1, a2, a3, a4, dn, py;
        a1 = (m_age == 1);
        a2 = (m_age == 2);
        a3 = (m_age == 3);
        a4 = (m_age == 4);
        py = a2;
        dn = a4;
`ifdef BRANCH_FAST_NOT_TAKEN_EN
        if (a2 && !bif.con) begin
            py = 0;
            dn = 1;
        end
`endif
        return {(m_age != 0), dn, m_taken, m_c2q,
                a1, a1, a1,
                py, py,
                a3, a3, a3,
                a4, a4 & bif.con,
                m_bc, m_tc};
    endfunction

    task automatic cyc(input logic st, input logic [1:0] cc,
                       input logic cn, input logic rn);
        bif.start = st;
        bif.c2    = cc;
        bif.con   = cn;
        reset_n   = rn;
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(0, 2'b00, 0, 0);
        cyc(0, 2'b00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 2'b00, 0, 1);
            checks++;
            if (obs_vec() !== '0) begin
                $display("FAIL reset_idle: got %h want 0",
                         obs_vec());
                errors++;
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL reset_model: got %h want %h",
                         obs_vec(), exp_vec());
                errors++;
            end
        end
    endtask

    task automatic test_taken();
        cyc(0, 2'b00, 0, 0);
        cyc(1, 2'b00, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL taken_seq%0d: got %h want %h",
                         k, obs_vec(), exp_vec());
                errors++;
            end
            checks++;
            if (bif.done !== (k == 4) ||
                bif.con_in !== (k == 1) ||
                bif.y_in !== (k == 2) ||
                bif.z_in !== (k == 3) ||
                bif.pc_in !== (k == 4)) begin
                $display("FAIL taken_strobe%0d: got %h want stage %0d",
                         k, obs_vec(), k);
                errors++;
            end
            cyc(0, 2'b00, 1, 1);
        end
        checks++;
        if ({bif.taken, bif.branch_count, bif.taken_count}
            !== {1'b1, 4'd1, 4'd1}) begin
            $display("FAIL taken_stats: got %b/%0d/%0d want 1/1/1",
                     bif.taken, bif.branch_count, bif.taken_count);
            errors++;
        end
    endtask

    task automatic test_not_taken();
        int dc;
`ifdef BRANCH_FAST_NOT_TAKEN_EN
        dc = 2;
`else
        dc = 4;
`endif
        cyc(0, 2'b00, 0, 0);
        cyc(1, 2'b01, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL nt_seq%0d: got %h want %h",
                         k, obs_vec(), exp_vec());
                errors++;
            end
            checks++;
            if (bif.done !== (k == dc) || bif.pc_in !== 1'b0) begin
                $display("FAIL nt_done%0d: got done=%b pc_in=%b want %b/0",
                         k, bif.done, bif.pc_in, (k == dc));
                errors++;
            end
            cyc(0, 2'b00, 0, 1);
        end
        checks++;
        if ({bif.taken, bif.branch_count, bif.taken_count}
            !== {1'b0, 4'd1, 4'd0}) begin
            $display("FAIL nt_stats: got %b/%0d/%0d want 0/1/0",
                     bif.taken, bif.branch_count, bif.taken_count);
            errors++;
        end
    endtask

    task automatic test_start_while_busy();
        cyc(0, 2'b00, 0, 0);
        cyc(1, 2'b10, 1, 1);
        cyc(0, 2'b00, 1, 1);
        cyc(1, 2'b11, 1, 1);
        checks++;
        if (bif.c2_q !== 2'b10) begin
            $display("FAIL busy_c2q: got %b want 10", bif.c2_q);
            errors++;
        end
        cyc(0, 2'b00, 1, 1);
        cyc(1, 2'b01, 1, 1);
        cyc(0, 2'b00, 1, 1);
        cyc(0, 2'b00, 1, 1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL busy_model: got %h want %h",
                     obs_vec(), exp_vec());
            errors++;
        end
        checks++;
        if ({bif.busy, bif.c2_q, bif.branch_count}
            !== {1'b0, 2'b10, 4'd1}) begin
            $display("FAIL busy_stats: got %b/%b/%0d want 0/10/1",
                     bif.busy, bif.c2_q, bif.branch_count);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        bit saw_pc;
        cyc(0, 2'b00, 0, 0);
        cyc(1, 2'b00, 1, 1);
        cyc(0, 2'b00, 1, 1);
        cyc(0, 2'b00, 1, 1);
        checks++;
        if (bif.alu_add !== 1'b1) begin
            $display("FAIL mid_addc: got alu_add=%b want 1", bif.alu_add);
            errors++;
        end
        cyc(0, 2'b00, 1, 0);
        checks++;
        if (obs_vec() !== '0) begin
            $display("FAIL mid_reset: got %h want 0", obs_vec());
            errors++;
        end
        saw_pc = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 2'b00, 1, 1);
            if (bif.pc_in === 1'b1) saw_pc = 1;
        end
        checks++;
        if (saw_pc || bif.branch_count !== 4'd0) begin
            $display("FAIL mid_abort: got pc_in=%b count=%0d want 0/0",
                     saw_pc, bif.branch_count);
            errors++;
        end
    endtask

    task automatic test_saturation();
        cyc(0, 2'b00, 0, 0);
        for (int b = 0; b < 20; b++) begin
            cyc(1, 2'(b), 1, 1);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    $display("FAIL sat_seq%0d: got %h want %h",
                             b, obs_vec(), exp_vec());
                    errors++;
                end
                cyc(0, 2'b00, 1, 1);
            end
        end
        checks++;
        if ({bif.branch_count, bif.taken_count} !== {4'd15, 4'd15}) begin
            $display("FAIL sat_counts: got %0d/%0d want 15/15",
                     bif.branch_count, bif.taken_count);
            errors++;
        end
    endtask

    task automatic test_random();
        cyc(0, 2'b00, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 3) == 0,
                2'($urandom),
                1'($urandom),
                ($urandom % 97) != 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL random%0d: got %h want %h",
                         i, obs_vec(), exp_vec());
                errors++;
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        bif.start = 1'b0;
        bif.c2    = 2'b00;
        bif.con   = 1'b0;
        m_age = 0; m_taken = 0; m_c2q = 0;
        m_bc = 0; m_tc = 0;
        @(negedge clk);
        test_reset();
        test_taken();
        test_not_taken();
        test_start_while_busy();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
